// File: rtl/clk_seq_pkg.sv
// Shared definitions for the phase-programmable clock sequencer:
// minimum divide ratio and the channel / ratio-change state encodings.
package clk_seq_pkg;

   localparam int MIN_DIV = 2;

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_RUN   = 2'd1,
      CH_DRAIN = 2'd2
   } ch_state_t;

   typedef enum logic {
      DIV_RUN     = 1'b0,
      DIV_PENDING = 1'b1
   } div_state_t;

endpackage

// File: rtl/clk_phase_channel.sv
// One divided-clock channel: phase compare against the shared counter, an
// enable FSM that only starts or stops on whole high phases, and output/rise registers.
module clk_phase_channel
   import clk_seq_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic [DIV_W-1:0] cnt,
   input  logic [DIV_W-1:0] div_active,
   input  logic             en,
   input  logic             invert,
   input  logic [DIV_W-1:0] offset,
   output logic             clk_out,
   output logic             rise
);

   logic [DIV_W:0] div_x;
   logic [DIV_W:0] off_x;
   logic [DIV_W:0] sum;
   logic [DIV_W:0] ph;
   logic [DIV_W:0] half;
   logic           raw;
   ch_state_t      state;
   ch_state_t      state_nxt;
   logic           out_nxt;
   logic           rise_nxt;

   // Odd ratios round the high half up, so the extra cycle lands in the high phase.
   always_comb begin
      div_x = {1'b0, div_active};
      off_x = (offset >= div_active) ? '0 : {1'b0, offset};
      sum   = {1'b0, cnt} + div_x - off_x;
      ph    = (sum >= div_x) ? (sum - div_x) : sum;
      half  = (div_x + (DIV_W+1)'(1)) >> 1;
      raw   = (ph < half);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CH_IDLE:  if (en && (ph == '0)) state_nxt = CH_RUN;
         CH_RUN:   if (!en) state_nxt = raw ? CH_DRAIN : CH_IDLE;
         CH_DRAIN: begin
            if (en)       state_nxt = CH_RUN;
            else if (!raw) state_nxt = CH_IDLE;
         end
         default:  state_nxt = CH_IDLE;
      endcase
      out_nxt  = (state_nxt == CH_IDLE) ? invert : (raw ^ invert);
      rise_nxt = (state_nxt != CH_IDLE) && out_nxt && !clk_out;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= CH_IDLE;
         clk_out <= 1'b0;
         rise    <= 1'b0;
      end else if (stall) begin
         rise    <= 1'b0;
      end else begin
         state   <= state_nxt;
         clk_out <= out_nxt;
         rise    <= rise_nxt;
      end
   end

endmodule

// File: rtl/clk_phase_sequencer.sv
// Multi-channel divided clock generator: shared phase counter, ratio-change
// FSM applying new ratios only at period boundaries, and one channel per output.
module clk_phase_sequencer
   import clk_seq_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 4,
   parameter int DEFAULT_DIV = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DIV_W-1:0]        div_ratio,
   input  logic                    div_load,
   output logic                    div_ack,
   output logic [DIV_W-1:0]        div_active,
   input  logic                    stall,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH-1:0]       ch_invert,
   input  logic [NUM_CH*DIV_W-1:0] ch_offset,
   output logic [NUM_CH-1:0]       ch_clk_out,
   output logic [NUM_CH-1:0]       ch_rise
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] div_nxt;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] pend_nxt;
   logic [DIV_W-1:0] req_div;
   logic             ack_nxt;
   logic             wrap;
   div_state_t       gstate;
   div_state_t       gstate_nxt;

   assign req_div = (div_ratio < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_ratio;
   assign wrap    = (cnt == (div_active - DIV_W'(1)));

   // A load arriving on the boundary cycle wins over the older pending value.
   always_comb begin
      gstate_nxt = gstate;
      cnt_nxt    = cnt;
      div_nxt    = div_active;
      pend_nxt   = pend_div;
      ack_nxt    = 1'b0;
      if (!stall) cnt_nxt = wrap ? '0 : (cnt + DIV_W'(1));
      if (div_load) begin
         pend_nxt   = req_div;
         gstate_nxt = DIV_PENDING;
      end
      if (!stall && (gstate == DIV_PENDING) && wrap) begin
         div_nxt    = div_load ? req_div : pend_div;
         cnt_nxt    = '0;
         ack_nxt    = 1'b1;
         gstate_nxt = DIV_RUN;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gstate     <= DIV_RUN;
         cnt        <= '0;
         div_active <= DIV_W'(DEFAULT_DIV);
         pend_div   <= '0;
         div_ack    <= 1'b0;
      end else begin
         gstate     <= gstate_nxt;
         cnt        <= cnt_nxt;
         div_active <= div_nxt;
         pend_div   <= pend_nxt;
         div_ack    <= ack_nxt;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_phase_channel #(.DIV_W(DIV_W)) u_ch (
         .clock      (clock),
         .reset      (reset),
         .stall      (stall),
         .cnt        (cnt),
         .div_active (div_active),
         .en         (ch_en[i]),
         .invert     (ch_invert[i]),
         .offset     (ch_offset[i*DIV_W +: DIV_W]),
         .clk_out    (ch_clk_out[i]),
         .rise       (ch_rise[i])
      );
   end

endmodule
